// File: rtl/merge_sched_pkg.sv
// Shared types and constants for the merge scheduler and later merge-tree levels.
package merge_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Every merge job ends with one extra terminator beat after both runs.
  localparam int unsigned TERM_BEATS = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts at ptr and wraps N-1 -> 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k;
      logic [IW-1:0] kk;
      k  = (int'(ptr) + i) % N;
      kk = IW'(k);
      if (!found && req[kk]) begin
        found   = 1'b1;
        gnt[kk] = 1'b1;
        idx     = kk;
      end
    end
  end

endmodule

// File: rtl/merge_scheduler.sv
// Round-robin scheduler granting one shared merger to NUM_REQ requesters, one job at a time.
// Optional stall watchdog compiled in with MERGE_SCHED_WATCHDOG_EN.
module merge_scheduler
  import merge_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int LEN_WIDTH  = 32,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0] i_len_a,
  input  logic [NUM_REQ*LEN_WIDTH-1:0] i_len_b,
  input  logic                         i_out_write,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [$clog2(NUM_REQ)-1:0]   o_done_id,
  output logic                         o_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = LEN_WIDTH + 1;

  state_t               state, state_n;
  logic [NUM_REQ-1:0]   grant, grant_n;
  logic                 busy, busy_n;
  logic                 done, done_n;
  logic [IW-1:0]        done_id, done_id_n;
  logic [IW-1:0]        winner, winner_n;
  logic [IW-1:0]        rr_ptr, rr_ptr_n;
  logic [TW-1:0]        total, total_n;
  logic [TW-1:0]        cnt, cnt_n;
  logic [TW-1:0]        cnt_inc;
  logic [IW-1:0]        ptr_next;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic [LEN_WIDTH-1:0] len_a_sel, len_b_sel;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req (i_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign len_a_sel = i_len_a[arb_idx*LEN_WIDTH +: LEN_WIDTH];
  assign len_b_sel = i_len_b[arb_idx*LEN_WIDTH +: LEN_WIDTH];
  assign cnt_inc   = cnt + TW'(1);
  assign ptr_next  = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

`ifdef MERGE_SCHED_WATCHDOG_EN
  localparam int SW = $clog2(WDOG_LIMIT + 1);
  logic [SW-1:0] stall, stall_n;
  logic          err, err_n;
  logic          stall_last;
  assign stall_last = (stall == SW'(WDOG_LIMIT - 1));
  assign o_err      = err;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_LIMIT;
  assign o_err       = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    busy_n    = busy;
    done_n    = 1'b0;
    done_id_n = done_id;
    winner_n  = winner;
    rr_ptr_n  = rr_ptr;
    total_n   = total;
    cnt_n     = cnt;
`ifdef MERGE_SCHED_WATCHDOG_EN
    stall_n   = stall;
    err_n     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|i_req) begin
          // TW-bit sum: max lengths plus terminator cannot wrap.
          total_n  = TW'(len_a_sel) + TW'(len_b_sel) + TW'(TERM_BEATS);
          cnt_n    = '0;
          winner_n = arb_idx;
          grant_n  = arb_gnt;
          busy_n   = 1'b1;
          state_n  = RUN;
        end
      end
      RUN: begin
        if (i_out_write) begin
          cnt_n = cnt_inc;
`ifdef MERGE_SCHED_WATCHDOG_EN
          stall_n = '0;
`endif
          if (cnt_inc == total) begin
            grant_n   = '0;
            busy_n    = 1'b0;
            done_n    = 1'b1;
            done_id_n = winner;
            state_n   = DONE;
          end
        end
`ifdef MERGE_SCHED_WATCHDOG_EN
        else if (stall_last) begin
          // Abort: release the merger and give the next requester its turn.
          stall_n  = '0;
          err_n    = 1'b1;
          grant_n  = '0;
          busy_n   = 1'b0;
          rr_ptr_n = ptr_next;
          state_n  = IDLE;
        end else begin
          stall_n = stall + 1'b1;
        end
`endif
      end
      DONE: begin
        rr_ptr_n = ptr_next;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      winner  <= '0;
      rr_ptr  <= '0;
      total   <= '0;
      cnt     <= '0;
`ifdef MERGE_SCHED_WATCHDOG_EN
      stall   <= '0;
      err     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      busy    <= busy_n;
      done    <= done_n;
      done_id <= done_id_n;
      winner  <= winner_n;
      rr_ptr  <= rr_ptr_n;
      total   <= total_n;
      cnt     <= cnt_n;
`ifdef MERGE_SCHED_WATCHDOG_EN
      stall   <= stall_n;
      err     <= err_n;
`endif
    end
  end

  assign o_grant   = grant;
  assign o_busy    = busy;
  assign o_done    = done;
  assign o_done_id = done_id;

endmodule
